// File: rtl/mem_load_ctrl.sv
// mem_load_ctrl: sequencing controller that fills a 512x32 word memory from a byte stream.
//
// Bytes arrive over a valid/ready handshake. The controller drives the external byte shift
// register's clear/shift/load strobes so that four bytes form one big-endian word (first byte
// in [31:24]). It writes each word to a wrapping address. When VERIFY is set it also reads the
// word back and compares it. While busy, this block is the only source of mem_we.
//
// Parameters
//   ADDR_W    memory address width (512 words)
//   DATA_W    memory word width
//   VERIFY    1 = read back and compare every written word, 0 = skip readback
//
// Ports
//   clk_           in   clock, rising edge
//   rst_           in   asynchronous, active-high reset
//   start          in   begin a load (sampled only when idle)
//   base_addr      in   first word address, latched on start
//   word_cnt       in   words to load (0..512, larger values saturate), latched on start
//   in_valid       in   byte available
//   in_data        in   byte, MSB-first within a word
//   in_ready       out  byte accepted this cycle (only combinational path: state == GET)
//   sr_clr         out  clear shift register
//   sr_shift       out  shift register left by 8, zero fill
//   sr_load        out  load sr_byte into shift register bits [7:0]
//   sr_byte        out  registered accepted byte
//   sr_word        in   shift register contents
//   mem_addr       out  memory address
//   mem_we         out  memory write enable
//   mem_wdata      out  write data (the shift register word)
//   mem_rdata      in   memory read data, one-cycle synchronous read
//   busy           out  high in every state except idle
//   done           out  one-cycle pulse at end of a load
//   err            out  sticky readback mismatch, cleared by start
//   words_written  out  words written since the last start

module mem_load_ctrl #(
  parameter int unsigned ADDR_W = 9,
  parameter int unsigned DATA_W = 32,
  parameter bit          VERIFY = 1'b1
) (
  input  logic              clk_,
  input  logic              rst_,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   word_cnt,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              sr_clr,
  output logic              sr_shift,
  output logic              sr_load,
  output logic [7:0]        sr_byte,
  input  logic [DATA_W-1:0] sr_word,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   words_written
);

  // Count-width constants; MaxWords is the memory depth (2**ADDR_W).
  localparam logic [ADDR_W:0]   MaxWords = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0]   CntOne   = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] AddrOne  = {{(ADDR_W-1){1'b0}}, 1'b1};

  typedef enum logic [3:0] {
    StIdle,
    StClr,
    StGet,
    StLoad,
    StShift,
    StWrite,
    StRaddr,
    StRchk,
    StDone
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W:0]   rem_q, rem_d;
  logic [1:0]        idx_q, idx_d;
  logic [7:0]        byte_q, byte_d;
  logic              err_q, err_d;
  logic [ADDR_W:0]   wr_q, wr_d;
  logic              word_end;

  always_ff @(posedge clk_ or posedge rst_) begin
    if (rst_) begin
      state_q <= StIdle;
      addr_q  <= '0;
      rem_q   <= '0;
      idx_q   <= '0;
      byte_q  <= '0;
      err_q   <= 1'b0;
      wr_q    <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      idx_q   <= idx_d;
      byte_q  <= byte_d;
      err_q   <= err_d;
      wr_q    <= wr_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    rem_d    = rem_q;
    idx_d    = idx_q;
    byte_d   = byte_q;
    err_d    = err_q;
    wr_d     = wr_q;
    word_end = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          addr_d  = base_addr;
          rem_d   = (word_cnt > MaxWords) ? MaxWords : word_cnt;
          err_d   = 1'b0;
          wr_d    = '0;
          state_d = (word_cnt == '0) ? StDone : StClr;
        end
      end
      StClr: begin
        idx_d   = 2'd0;
        state_d = StGet;
      end
      StGet: begin
        if (in_valid) begin
          byte_d  = in_data;
          state_d = StLoad;
        end
      end
      StLoad: begin
        state_d = (idx_q == 2'd3) ? StWrite : StShift;
      end
      StShift: begin
        idx_d   = idx_q + 2'd1;
        state_d = StGet;
      end
      StWrite: begin
        wr_d = wr_q + CntOne;
        if (VERIFY) begin
          state_d = StRaddr;
        end else begin
          word_end = 1'b1;
        end
      end
      StRaddr: begin
        // Address is already on mem_addr; the synchronous read lands during StRchk.
        state_d = StRchk;
      end
      StRchk: begin
        if (mem_rdata != sr_word) begin
          err_d = 1'b1;
        end
        word_end = 1'b1;
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // Shared end-of-word step: advance the wrapping address and retire one word.
    if (word_end) begin
      addr_d  = addr_q + AddrOne;
      rem_d   = rem_q - CntOne;
      state_d = (rem_q == CntOne) ? StDone : StClr;
    end
  end

  // Strobes are decoded from the state register only, so at most one is high per cycle
  // and all of them drop the instant reset is applied.
  assign in_ready      = (state_q == StGet);
  assign sr_clr        = (state_q == StClr);
  assign sr_load       = (state_q == StLoad);
  assign sr_shift      = (state_q == StShift);
  assign mem_we        = (state_q == StWrite);
  assign done          = (state_q == StDone);
  assign busy          = (state_q != StIdle);
  assign mem_addr      = addr_q;
  assign mem_wdata     = sr_word;
  assign sr_byte       = byte_q;
  assign err           = err_q;
  assign words_written = wr_q;

endmodule

// File: tb/tb_mem_load_ctrl.sv
module tb_mem_load_ctrl;

  logic        clk_ = 1'b0;
  logic        rst_;
  logic        start;
  logic [8:0]  base_addr;
  logic [9:0]  word_cnt;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        sr_clr, sr_shift, sr_load;
  logic [7:0]  sr_byte;
  logic [31:0] sr_word = '0;
  logic [8:0]  mem_addr;
  logic        mem_we;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic        busy, done, err;
  logic [9:0]  words_written;

  mem_load_ctrl #(.ADDR_W(9), .DATA_W(32), .VERIFY(1'b1)) dut (
    .clk_          (clk_),
    .rst_          (rst_),
    .start         (start),
    .base_addr     (base_addr),
    .word_cnt      (word_cnt),
    .in_valid      (in_valid),
    .in_data       (in_data),
    .in_ready      (in_ready),
    .sr_clr        (sr_clr),
    .sr_shift      (sr_shift),
    .sr_load       (sr_load),
    .sr_byte       (sr_byte),
    .sr_word       (sr_word),
    .mem_addr      (mem_addr),
    .mem_we        (mem_we),
    .mem_wdata     (mem_wdata),
    .mem_rdata     (mem_rdata),
    .busy          (busy),
    .done          (done),
    .err           (err),
    .words_written (words_written)
  );

  always #5 clk_ = ~clk_;

  int passed = 0;
  int failed = 0;
  int total  = 0;
  int cyc    = 0;
  int onehot_bad = 0;
  string tname = "reset";

  logic [31:0] mem [512];
  logic        corrupt_on   = 1'b0;
  logic [8:0]  corrupt_addr = '0;
  logic [40:0] wlog [$];
  logic [7:0]  bytes_in [$];
  logic [7:0]  drv_b [$];
  int          stalls_in [$];
  int          drv_s [$];

  // Environment: byte shift register and 512x32 synchronous memory.
  always @(posedge clk_) begin
    if (sr_clr) sr_word <= '0;
    else if (sr_shift) sr_word <= sr_word << 8;
    else if (sr_load) sr_word[7:0] <= sr_byte;
  end

  always @(posedge clk_) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    mem_rdata <= (corrupt_on && mem_addr == corrupt_addr) ? 32'h0 : mem[mem_addr];
  end

  always @(posedge clk_) begin
    cyc <= cyc + 1;
    if (mem_we) wlog.push_back({mem_addr, mem_wdata});
  end

  always @(negedge clk_) begin
    if (!rst_ && ($countones({sr_clr, sr_shift, sr_load, mem_we}) > 1))
      onehot_bad <= onehot_bad + 1;
  end

  // Byte source: waits for in_ready, idles drv_s[0] GET cycles, then offers drv_b[0].
  initial begin
    in_valid = 1'b0;
    in_data  = '0;
    forever begin
      @(negedge clk_);
      if (in_valid) begin
        if (drv_b.size() > 0) begin
          void'(drv_b.pop_front());
          void'(drv_s.pop_front());
        end
        in_valid = 1'b0;
      end
      if (rst_) in_valid = 1'b0;
      else if (in_ready && drv_b.size() > 0) begin
        if (drv_s[0] > 0) drv_s[0] = drv_s[0] - 1;
        else begin
          in_valid = 1'b1;
          in_data  = drv_b[0];
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s/%s: observed 0x%0h expected 0x%0h", tname, tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] word_of(input int i);
    return {bytes_in[4*i], bytes_in[4*i+1], bytes_in[4*i+2], bytes_in[4*i+3]};
  endfunction

  function automatic logic [34:0] outvec();
    return {in_ready, sr_clr, sr_shift, sr_load, mem_we, busy, done, err,
            sr_byte, mem_addr, words_written};
  endfunction

  // One load from bytes_in/stalls_in; cidx >= 0 corrupts the readback of that word.
  task automatic run_load(input logic [8:0] base, input logic [9:0] cnt, input int cidx,
                          input bit poke);
    int n, stalls, s, meas, bad, exp_cyc;
    bit exp_err, got;
    n = (cnt > 10'd512) ? 512 : int'(cnt);
    stalls = 0;
    foreach (stalls_in[i]) stalls += stalls_in[i];
    exp_cyc = 1 + 15 * n + stalls;
    exp_err = 1'b0;
    wlog.delete();
    corrupt_on = 1'b0;
    if (cidx >= 0) begin
      corrupt_addr = 9'(int'(base) + cidx);
      corrupt_on   = 1'b1;
      exp_err      = (word_of(cidx) != 32'h0);
    end
    drv_b = bytes_in;
    drv_s = stalls_in;
    @(negedge clk_);
    start = 1'b1; base_addr = base; word_cnt = cnt;
    @(posedge clk_);
    #1 s = cyc;
    @(negedge clk_);
    start = 1'b0;
    chk("busy_after_start", 64'(busy), 64'(1));
    chk("err_cleared_by_start", 64'(err), 64'(0));
    got = 1'b0;
    meas = 0;
    for (int k = 1; k <= exp_cyc + 40; k++) begin
      if (k > 1) @(negedge clk_);
      if (poke && k == 4) begin
        start = 1'b1; base_addr = ~base; word_cnt = 10'd3;
      end
      if (poke && k == 5) start = 1'b0;
      if (done) begin
        got = 1'b1;
        meas = cyc - s + 1;
        break;
      end
    end
    chk("done_seen", 64'(got), 64'(1));
    if (got) begin
      chk("done_cycle", 64'(meas), 64'(exp_cyc));
      chk("err_at_done", 64'(err), 64'(exp_err));
      chk("words_written", 64'(words_written), 64'(n));
      bad = 0;
      for (int i = 0; i < n; i++) begin
        if (i >= wlog.size()) bad++;
        else if (wlog[i] !== {9'(int'(base) + i), word_of(i)}) bad++;
      end
      chk("write_count", 64'(wlog.size()), 64'(n));
      chk("write_content_bad", 64'(bad), 64'(0));
      @(negedge clk_);
      chk("done_pulse_width", 64'(done), 64'(0));
      chk("idle_after_done", 64'(busy), 64'(0));
      chk("err_sticky", 64'(err), 64'(exp_err));
    end
    corrupt_on = 1'b0;
  endtask

  task automatic rand_bytes(input int n, input int max_stall);
    bytes_in.delete();
    stalls_in.delete();
    for (int i = 0; i < 4 * n; i++) begin
      bytes_in.push_back(8'($urandom));
      stalls_in.push_back(int'($urandom_range(32'(max_stall), 0)));
    end
  endtask

  int n_w, ci, shifts;

  initial begin
    rst_ = 1'b1; start = 1'b0; base_addr = '0; word_cnt = '0;
    @(negedge clk_);
    chk("reset_outputs", 64'(outvec()), 64'(0));
    @(negedge clk_);
    rst_ = 1'b0;

    tname = "deadbeef";
    bytes_in = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    stalls_in = '{0, 0, 0, 0};
    run_load(9'h005, 10'd1, -1, 1'b0);

    tname = "wrap";
    rand_bytes(2, 0);
    run_load(9'h1FF, 10'd2, -1, 1'b0);

    tname = "stalls";
    bytes_in = '{8'h11, 8'h22, 8'h33, 8'h44};
    stalls_in = '{0, 3, 3, 3};
    run_load(9'h0A0, 10'd1, -1, 1'b0);

    tname = "verify_err";
    bytes_in = '{8'hCA, 8'hFE, 8'hF0, 8'h0D};
    stalls_in = '{0, 0, 0, 0};
    run_load(9'h040, 10'd1, 0, 1'b0);

    tname = "err_clear";
    rand_bytes(3, 1);
    run_load(9'h041, 10'd3, -1, 1'b0);

    tname = "mid_reset";
    rand_bytes(1, 0);
    wlog.delete();
    drv_b = bytes_in;
    drv_s = stalls_in;
    @(negedge clk_);
    start = 1'b1; base_addr = 9'h123; word_cnt = 10'd1;
    @(negedge clk_);
    start = 1'b0;
    shifts = 0;
    for (int k = 0; k < 40 && shifts < 2; k++) begin
      if (sr_shift) shifts++;
      if (shifts < 2) @(negedge clk_);
    end
    chk("reached_second_shift", 64'(shifts), 64'(2));
    #1 rst_ = 1'b1;
    #1 chk("async_reset_outputs", 64'(outvec()), 64'(0));
    drv_b.delete();
    drv_s.delete();
    @(negedge clk_);
    @(negedge clk_);
    chk("no_write_on_reset", 64'(wlog.size()), 64'(0));
    rst_ = 1'b0;
    tname = "after_reset";
    rand_bytes(1, 0);
    run_load(9'h123, 10'd1, -1, 1'b0);

    tname = "zero_count";
    bytes_in.delete();
    stalls_in.delete();
    run_load(9'h077, 10'd0, -1, 1'b0);

    tname = "start_while_busy";
    rand_bytes(2, 0);
    run_load(9'h1F0, 10'd2, -1, 1'b1);

    for (int t = 0; t < 6; t++) begin
      tname = $sformatf("random%0d", t);
      n_w = int'($urandom_range(6, 1));
      rand_bytes(n_w, 2);
      ci = ($urandom_range(2, 0) == 0) ? int'($urandom_range(32'(n_w - 1), 0)) : -1;
      run_load(9'($urandom), 10'(n_w), ci, 1'b0);
    end

    tname = "saturate";
    rand_bytes(512, 0);
    run_load(9'($urandom), 10'd600, -1, 1'b0);

    tname = "final";
    chk("strobe_onehot_violations", 64'(onehot_bad), 64'(0));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
